// File: rtl/stage_2_decode.sv
// rtl/stage_2_decode.sv - RV32I decode stage: register file, immediate/control decode, load-use stall
// Outputs are a registered bundle; flush and load-use hazards replace it with an all-zero bubble.
module stage_2_decode (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_next_address,
    input  logic        i_flush,
    input  logic        i_wb_enable,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_data,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_rs1_value,
    output logic [31:0] o_rs2_value,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [3:0]  o_alu_op,
    output logic        o_a_sel_pc,
    output logic        o_b_sel_imm,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_branch,
    output logic        o_jal,
    output logic        o_jalr,
    output logic        o_illegal,
    output logic [2:0]  o_mem_size
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [31:0] w_rs1_read;
    logic [31:0] w_rs2_read;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    logic [31:0] w_imm;
    logic [3:0]  w_alu_op;
    logic        w_a_sel_pc;
    logic        w_b_sel_imm;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_jal;
    logic        w_jalr;
    logic        w_illegal;
    logic [2:0]  w_mem_size;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_lui;
    logic        w_bubble;

    assign w_opcode  = i_instruction[6:0];
    assign w_rd      = i_instruction[11:7];
    assign w_funct3  = i_instruction[14:12];
    assign w_rs1_idx = i_instruction[19:15];
    assign w_rs2_idx = i_instruction[24:20];

    assign w_imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
    assign w_imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign w_imm_b = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                      i_instruction[30:25], i_instruction[11:8], 1'b0};
    assign w_imm_u = {i_instruction[31:12], 12'b0};
    assign w_imm_j = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                      i_instruction[20], i_instruction[30:21], 1'b0};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_enable && (i_wb_reg != 5'd0)) begin
            r_regs[i_wb_reg] <= i_wb_data;
        end
    end

    // Same-cycle writeback bypasses the array so the decode sees the new value.
    always_comb begin
        w_rs1_read = '0;
        w_rs2_read = '0;
        if (w_rs1_idx != 5'd0) begin
            w_rs1_read = (i_wb_enable && (i_wb_reg == w_rs1_idx)) ? i_wb_data : r_regs[w_rs1_idx];
        end
        if (w_rs2_idx != 5'd0) begin
            w_rs2_read = (i_wb_enable && (i_wb_reg == w_rs2_idx)) ? i_wb_data : r_regs[w_rs2_idx];
        end
    end

    always_comb begin
        w_imm       = '0;
        w_alu_op    = '0;
        w_a_sel_pc  = 1'b0;
        w_b_sel_imm = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jal       = 1'b0;
        w_jalr      = 1'b0;
        w_illegal   = 1'b0;
        w_mem_size  = '0;
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b0;
        w_lui       = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_imm       = w_imm_u;
                w_b_sel_imm = 1'b1;
                w_reg_write = 1'b1;
                w_use_rs1   = 1'b0;
                w_lui       = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm       = w_imm_u;
                w_a_sel_pc  = 1'b1;
                w_b_sel_imm = 1'b1;
                w_reg_write = 1'b1;
                w_use_rs1   = 1'b0;
            end
            OPC_JAL: begin
                w_imm       = w_imm_j;
                w_a_sel_pc  = 1'b1;
                w_b_sel_imm = 1'b1;
                w_reg_write = 1'b1;
                w_jal       = 1'b1;
                w_use_rs1   = 1'b0;
            end
            OPC_JALR: begin
                w_imm       = w_imm_i;
                w_b_sel_imm = 1'b1;
                w_reg_write = 1'b1;
                w_jalr      = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm       = w_imm_b;
                w_branch    = 1'b1;
                w_use_rs2   = 1'b1;
            end
            OPC_LOAD: begin
                w_imm       = w_imm_i;
                w_b_sel_imm = 1'b1;
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
                w_mem_size  = w_funct3;
            end
            OPC_STORE: begin
                w_imm       = w_imm_s;
                w_b_sel_imm = 1'b1;
                w_mem_write = 1'b1;
                w_mem_size  = w_funct3;
                w_use_rs2   = 1'b1;
            end
            OPC_OPIMM: begin
                w_imm       = w_imm_i;
                w_b_sel_imm = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = {(w_funct3 == 3'b101) & i_instruction[30], w_funct3};
            end
            OPC_OP: begin
                w_reg_write = 1'b1;
                w_alu_op    = {i_instruction[30], w_funct3};
                w_use_rs2   = 1'b1;
            end
            default: begin
                w_illegal   = 1'b1;
                w_use_rs1   = 1'b0;
            end
        endcase
        if (w_rd == 5'd0) begin
            w_reg_write = 1'b0;
        end
    end

    // Load-use hazard against the load currently held in the output register.
    assign o_stall = ~i_reset & ~i_flush & o_valid & o_mem_read & (o_rd != 5'd0) &
                     ((w_use_rs1 & (w_rs1_idx == o_rd)) | (w_use_rs2 & (w_rs2_idx == o_rd)));

    assign w_bubble = i_flush | o_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || w_bubble) begin
            o_valid     <= 1'b0;
            o_pc        <= '0;
            o_next_pc   <= '0;
            o_rs1_value <= '0;
            o_rs2_value <= '0;
            o_imm       <= '0;
            o_rs1       <= '0;
            o_rs2       <= '0;
            o_rd        <= '0;
            o_alu_op    <= '0;
            o_a_sel_pc  <= 1'b0;
            o_b_sel_imm <= 1'b0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_branch    <= 1'b0;
            o_jal       <= 1'b0;
            o_jalr      <= 1'b0;
            o_illegal   <= 1'b0;
            o_mem_size  <= '0;
        end else begin
            o_valid     <= 1'b1;
            o_pc        <= i_next_address - 32'd4;
            o_next_pc   <= i_next_address;
            o_rs1_value <= w_lui ? 32'd0 : w_rs1_read;
            o_rs2_value <= w_rs2_read;
            o_imm       <= w_imm;
            o_rs1       <= w_lui ? 5'd0 : w_rs1_idx;
            o_rs2       <= w_rs2_idx;
            o_rd        <= w_rd;
            o_alu_op    <= w_alu_op;
            o_a_sel_pc  <= w_a_sel_pc;
            o_b_sel_imm <= w_b_sel_imm;
            o_reg_write <= w_reg_write;
            o_mem_read  <= w_mem_read;
            o_mem_write <= w_mem_write;
            o_branch    <= w_branch;
            o_jal       <= w_jal;
            o_jalr      <= w_jalr;
            o_illegal   <= w_illegal;
            o_mem_size  <= w_mem_size;
        end
    end

endmodule

// File: tb/tb_stage_2_decode.sv
// tb/tb_stage_2_decode.sv - directed self-checking bench for stage_2_decode
module tb_stage_2_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0000_0013;
    logic [31:0] next_address = 32'h0000_0004;
    logic        flush = 1'b0;
    logic        wb_enable = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        stall, valid, a_sel_pc, b_sel_imm, reg_write, mem_read, mem_write;
    logic        branch, jal, jalr, illegal;
    logic [31:0] pc, next_pc, rs1_value, rs2_value, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic [2:0]  mem_size;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stage_2_decode dut (
        .i_clk(clk), .i_reset(reset), .i_instruction(instruction), .i_next_address(next_address),
        .i_flush(flush), .i_wb_enable(wb_enable), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
        .o_stall(stall), .o_valid(valid), .o_pc(pc), .o_next_pc(next_pc),
        .o_rs1_value(rs1_value), .o_rs2_value(rs2_value), .o_imm(imm),
        .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd), .o_alu_op(alu_op),
        .o_a_sel_pc(a_sel_pc), .o_b_sel_imm(b_sel_imm), .o_reg_write(reg_write),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_branch(branch),
        .o_jal(jal), .o_jalr(jalr), .o_illegal(illegal), .o_mem_size(mem_size)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_total++; if (valid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", valid); else n_pass++;
        n_total++; if (pc !== 32'h0) $display("FAIL rst_pc got %0h exp 0", pc); else n_pass++;
        n_total++; if (next_pc !== 32'h0) $display("FAIL rst_next_pc got %0h exp 0", next_pc); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL rst_stall got %0h exp 0", stall); else n_pass++;
        n_total++; if (reg_write !== 1'b0) $display("FAIL rst_reg_write got %0h exp 0", reg_write); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_add();
        instruction = 32'h0000_0013;
        wb_enable = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234_5678;
        step();
        n_total++; if (valid !== 1'b1) $display("FAIL first_edge_valid got %0h exp 1", valid); else n_pass++;
        wb_enable = 1'b0;
        instruction = 32'h0000_83B3 | 32'h0002_0000; // add x7,x5,x0 = 0x000283B3
        next_address = 32'h0000_0204;
        step();
        n_total++; if (valid !== 1'b1) $display("FAIL add_valid got %0h exp 1", valid); else n_pass++;
        n_total++; if (rs1_value !== 32'h1234_5678) $display("FAIL add_rs1_value got %0h exp 12345678", rs1_value); else n_pass++;
        n_total++; if (alu_op !== 4'b0000) $display("FAIL add_alu_op got %0h exp 0", alu_op); else n_pass++;
        n_total++; if (reg_write !== 1'b1) $display("FAIL add_reg_write got %0h exp 1", reg_write); else n_pass++;
        n_total++; if (rd !== 5'd7) $display("FAIL add_rd got %0d exp 7", rd); else n_pass++;
        n_total++; if (b_sel_imm !== 1'b0) $display("FAIL add_b_sel_imm got %0h exp 0", b_sel_imm); else n_pass++;
        n_total++; if (pc !== 32'h0000_0200) $display("FAIL add_pc got %0h exp 200", pc); else n_pass++;
    endtask

    task automatic test_addi();
        instruction = 32'hFFF0_0093;
        next_address = 32'h0000_0104;
        step();
        n_total++; if (imm !== 32'hFFFF_FFFF) $display("FAIL addi_imm got %0h exp ffffffff", imm); else n_pass++;
        n_total++; if (pc !== 32'h0000_0100) $display("FAIL addi_pc got %0h exp 100", pc); else n_pass++;
        n_total++; if (next_pc !== 32'h0000_0104) $display("FAIL addi_next_pc got %0h exp 104", next_pc); else n_pass++;
        n_total++; if (b_sel_imm !== 1'b1) $display("FAIL addi_b_sel_imm got %0h exp 1", b_sel_imm); else n_pass++;
        n_total++; if (alu_op !== 4'b0000) $display("FAIL addi_alu_op got %0h exp 0", alu_op); else n_pass++;
    endtask

    task automatic test_load_use();
        instruction = 32'h0001_2183; // lw x3,0(x2)
        step();
        n_total++; if (mem_read !== 1'b1) $display("FAIL lw_mem_read got %0h exp 1", mem_read); else n_pass++;
        n_total++; if (mem_size !== 3'b010) $display("FAIL lw_mem_size got %0h exp 2", mem_size); else n_pass++;
        instruction = 32'h0031_8233; // add x4,x3,x3
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL lu_stall got %0h exp 1", stall); else n_pass++;
        step();
        n_total++; if (valid !== 1'b0) $display("FAIL lu_bubble_valid got %0h exp 0", valid); else n_pass++;
        n_total++; if (reg_write !== 1'b0) $display("FAIL lu_bubble_reg_write got %0h exp 0", reg_write); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL lu_stall_once got %0h exp 0", stall); else n_pass++;
        step();
        n_total++; if (valid !== 1'b1) $display("FAIL lu_add_valid got %0h exp 1", valid); else n_pass++;
        n_total++; if (rd !== 5'd4) $display("FAIL lu_add_rd got %0d exp 4", rd); else n_pass++;
        n_total++; if (rs2 !== 5'd3) $display("FAIL lu_add_rs2 got %0d exp 3", rs2); else n_pass++;
    endtask

    task automatic test_load_lui();
        wb_enable = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEAD_BEEF;
        instruction = 32'h0001_2183; // lw x3,0(x2)
        step();
        wb_enable = 1'b0;
        instruction = 32'h0001_81B7; // lui x3,0x18 (rs1 field happens to be 3)
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL lui_stall got %0h exp 0", stall); else n_pass++;
        step();
        n_total++; if (imm !== 32'h0001_8000) $display("FAIL lui_imm got %0h exp 18000", imm); else n_pass++;
        n_total++; if (rs1 !== 5'd0) $display("FAIL lui_rs1 got %0d exp 0", rs1); else n_pass++;
        n_total++; if (rs1_value !== 32'h0) $display("FAIL lui_rs1_value got %0h exp 0", rs1_value); else n_pass++;
        n_total++; if (a_sel_pc !== 1'b0) $display("FAIL lui_a_sel_pc got %0h exp 0", a_sel_pc); else n_pass++;
    endtask

    task automatic test_load_x0();
        instruction = 32'h0001_2003; // lw x0,0(x2)
        step();
        instruction = 32'h0000_0233; // add x4,x0,x0
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL lwx0_stall got %0h exp 0", stall); else n_pass++;
        n_total++; if (reg_write !== 1'b0) $display("FAIL lwx0_reg_write got %0h exp 0", reg_write); else n_pass++;
        step();
    endtask

    task automatic test_flush();
        instruction = 32'h0001_2183;
        step();
        instruction = 32'h0031_8233;
        flush = 1'b1;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL flush_stall got %0h exp 0", stall); else n_pass++;
        step();
        flush = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL flush_valid got %0h exp 0", valid); else n_pass++;
        n_total++; if (reg_write !== 1'b0) $display("FAIL flush_reg_write got %0h exp 0", reg_write); else n_pass++;
        n_total++; if (mem_write !== 1'b0) $display("FAIL flush_mem_write got %0h exp 0", mem_write); else n_pass++;
        n_total++; if (rd !== 5'd0) $display("FAIL flush_rd got %0d exp 0", rd); else n_pass++;
    endtask

    task automatic test_store_bypass();
        wb_enable = 1'b1; wb_reg = 5'd9; wb_data = 32'hA5A5_A5A5;
        instruction = 32'h0090_A423; // sw x9,8(x1)
        step();
        wb_enable = 1'b0;
        n_total++; if (rs2_value !== 32'hA5A5_A5A5) $display("FAIL sw_rs2_value got %0h exp a5a5a5a5", rs2_value); else n_pass++;
        n_total++; if (imm !== 32'h8) $display("FAIL sw_imm got %0h exp 8", imm); else n_pass++;
        n_total++; if (mem_write !== 1'b1) $display("FAIL sw_mem_write got %0h exp 1", mem_write); else n_pass++;
        n_total++; if (mem_size !== 3'b010) $display("FAIL sw_mem_size got %0h exp 2", mem_size); else n_pass++;
        n_total++; if (reg_write !== 1'b0) $display("FAIL sw_reg_write got %0h exp 0", reg_write); else n_pass++;
    endtask

    task automatic test_x0_write();
        wb_enable = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
        instruction = 32'h0000_03B3; // add x7,x0,x0
        step();
        n_total++; if (rs1_value !== 32'h0) $display("FAIL x0_bypass got %0h exp 0", rs1_value); else n_pass++;
        wb_enable = 1'b0;
        step();
        n_total++; if (rs1_value !== 32'h0) $display("FAIL x0_read got %0h exp 0", rs1_value); else n_pass++;
    endtask

    task automatic test_branch_illegal();
        instruction = 32'hFE20_8EE3; // beq x1,x2,-4
        next_address = 32'h0000_0000;
        step();
        n_total++; if (imm !== 32'hFFFF_FFFC) $display("FAIL beq_imm got %0h exp fffffffc", imm); else n_pass++;
        n_total++; if (branch !== 1'b1) $display("FAIL beq_branch got %0h exp 1", branch); else n_pass++;
        n_total++; if (b_sel_imm !== 1'b0) $display("FAIL beq_b_sel_imm got %0h exp 0", b_sel_imm); else n_pass++;
        n_total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL beq_pc_wrap got %0h exp fffffffc", pc); else n_pass++;
        instruction = 32'h0000_00FF; // opcode 1111111, rd=1
        step();
        n_total++; if (illegal !== 1'b1) $display("FAIL ill_illegal got %0h exp 1", illegal); else n_pass++;
        n_total++; if (valid !== 1'b1) $display("FAIL ill_valid got %0h exp 1", valid); else n_pass++;
        n_total++; if (reg_write !== 1'b0) $display("FAIL ill_reg_write got %0h exp 0", reg_write); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        wb_enable = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234_5678;
        instruction = 32'h0001_2183;
        step();
        wb_enable = 1'b0;
        instruction = 32'h0031_8233;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL mid_pre_stall got %0h exp 1", stall); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (valid !== 1'b0) $display("FAIL mid_valid got %0h exp 0", valid); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL mid_stall got %0h exp 0", stall); else n_pass++;
        n_total++; if (mem_read !== 1'b0) $display("FAIL mid_mem_read got %0h exp 0", mem_read); else n_pass++;
        step();
        reset = 1'b0;
        instruction = 32'h0002_83B3; // add x7,x5,x0
        next_address = 32'h0000_0008;
        step();
        n_total++; if (valid !== 1'b1) $display("FAIL post_rst_valid got %0h exp 1", valid); else n_pass++;
        n_total++; if (rs1_value !== 32'h0) $display("FAIL post_rst_x5 got %0h exp 0", rs1_value); else n_pass++;
        instruction = 32'h0090_A423;
        step();
        n_total++; if (rs2_value !== 32'h0) $display("FAIL post_rst_x9 got %0h exp 0", rs2_value); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_load_use();
        test_load_lui();
        test_load_x0();
        test_flush();
        test_store_bypass();
        test_x0_write();
        test_branch_illegal();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
